fpga_register_poller: RTL and testbench
=======================================

Name: fpga_register_poller

Overview:
- Avalon-MM read master. It periodically polls an 8-bit input-port slave: address 0, registered readdata, fixed read latency.
- Holds the latest sampled byte locally.
- Emits a one-cycle strobe carrying a per-bit change mask whenever the sampled value differs from the previous sample.
- Sits in FPGA fabric between the HPS-visible input-port register and radar control logic that needs event-driven notification of switch/status bits.

Parameters:
- ADDR_W, 2, width of avm_address.
- DATA_W, 32, width of avm_readdata.
- VALUE_W, 8, number of low readdata bits treated as the value; must be ≤ DATA_W.
- POLL_DIV, 1000, clock cycles between poll launches; minimum 4.
- READ_LAT, 1, fixed slave read latency in cycles; minimum 1.
- TIMEOUT_CYC, 256, waitrequest watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  periodic polling enable
- poll_now  in  1  single-cycle request for an immediate poll
- avm_address  out  ADDR_W  read address; always 0
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_W  read data; valid READ_LAT cycles after acceptance
- value  out  VALUE_W  last sampled value
- value_valid  out  1  high once the first sample has completed
- change_mask  out  VALUE_W  XOR of new and previous sample; valid with change_stb
- change_stb  out  1  one-cycle pulse when a sample differs from the previous one
- busy  out  1  high from request issue until sample capture
- timeout_err  out  1  sticky watchdog flag; tied 0 without the macro

Behaviour:
- Reset (synchronous, clk rising edge with reset=1):
  - state=IDLE, divider=POLL_DIV-1.
  - avm_read=0, value=0, value_valid=0, change_mask=0, change_stb=0, busy=0, timeout_err=0.
  - Reset mid-transaction drops avm_read the next cycle. Any in-flight readdata is ignored.
- Divider:
  - Decrements in IDLE while enable=1 and reloads to POLL_DIV-1 on reaching 0.
  - Reaching 0 raises a poll request.
  - enable=0 freezes the divider; it does not reset it.
- poll_now:
  - Sampled in any state; latched into a pending bit.
  - A pending or divider request in IDLE moves to REQ on the next edge. The pending bit clears on that transition.
  - A poll_now arriving in REQ or WAIT is serviced right after the current capture, so at most one is queued.
- States:
  - IDLE:
    - avm_read=0, busy=0.
    - Go to REQ when a request is present.
  - REQ:
    - avm_read=1, avm_address=0, busy=1.
    - Hold read and address stable while avm_waitrequest=1.
    - On the cycle with avm_read=1 and avm_waitrequest=0, the read is accepted: go to WAIT and load the latency counter with READ_LAT-1.
  - WAIT:
    - avm_read=0, busy=1.
    - Decrement the counter each cycle.
    - On the cycle where the counter is 0, sample avm_readdata[VALUE_W-1:0] and go to IDLE.
- Timing:
  - Acceptance at edge T; readdata is sampled at edge T+READ_LAT.
  - value and change outputs update at that edge and are visible in the following cycle.
  - Total latency from the request edge to value update: 1 + (waitrequest stall cycles) + READ_LAT.
- Capture:
  - new = readdata[VALUE_W-1:0].
  - change_mask = new XOR value, then value = new.
  - change_stb = 1 for exactly one cycle when value_valid was already 1 and the mask is non-zero.
  - The first sample after reset sets value_valid=1 and never strobes.
  - change_mask holds its last value until the next capture.
- Bits of readdata above VALUE_W are ignored.

Optional Feature:
- Macro: FPGA_REGISTER_POLLER_TIMEOUT_EN.
- When defined:
  - A counter runs while in REQ with avm_waitrequest=1.
  - On reaching TIMEOUT_CYC, deassert avm_read, return to IDLE, set timeout_err=1 (sticky until reset), and leave value unchanged.
- When undefined:
  - No counter logic.
  - REQ waits indefinitely.
  - timeout_err is constant 0.

Decomposition:
- Package fpga_register_poller_pkg holds:
  - the state enum (IDLE, REQ, WAIT);
  - the default POLL_DIV, READ_LAT and TIMEOUT_CYC constants;
  - the register offset constant VALUE_OFFSET=0.
- One natural sub-module, poll_divider: a free-running reloadable down-counter with enable and a terminal-count pulse.
- The FSM and capture logic stay in the top module.

Test Plan:
- Reset, then enable=1, POLL_DIV=8, READ_LAT=1, slave returns 0x5A, no waitrequest → first avm_read at cycle 8; value=0x5A and value_valid=1 two cycles after acceptance; change_stb never asserted.
- Slave value changes from 0x5A to 0x5B before the next poll → change_stb single pulse with change_mask=0x01, value=0x5B.
- avm_waitrequest held for 3 cycles → avm_read and avm_address stay stable for 4 cycles; capture occurs READ_LAT after the low-waitrequest cycle.
- enable=0, poll_now pulsed while idle, then again during WAIT → exactly two reads issued back-to-back, none after.
- Reset asserted during WAIT with readdata 0xFF → value=0, value_valid=0, no change_stb, avm_read=0 the next cycle.
- With FPGA_REGISTER_POLLER_TIMEOUT_EN, TIMEOUT_CYC=16 and waitrequest stuck at 1 → avm_read drops after 16 stalled cycles; timeout_err=1 and stays 1; value unchanged.

Source files
------------

// File: rtl/fpga_register_poller_pkg.sv
// fpga_register_poller_pkg
// Shared types and constants for the Avalon-MM input-port poller:
// FSM state encoding, default timing parameters, the polled register
// offset and a counter-width helper used by the poller and its divider.

package fpga_register_poller_pkg;

    // Poll FSM: idle between polls, read request on the bus, read-latency wait.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Default configuration.
    localparam int DEF_POLL_DIV    = 1000;
    localparam int DEF_READ_LAT    = 1;
    localparam int DEF_TIMEOUT_CYC = 256;

    // Word offset of the value register inside the input-port slave.
    localparam int VALUE_OFFSET    = 0;

    // Bits needed for a down-counter holding 0 .. span-1 (never less than 1).
    function automatic int cnt_width(input int span);
        if (span > 2) begin
            return $clog2(span);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/fpga_register_poller_divider.sv
// poll_divider
// Reloadable free-running down-counter. While 'run' is high it counts
// DIV-1 .. 0 and reloads; 'tick' is a one-cycle terminal-count pulse on
// the cycle the counter sits at 0 with 'run' high. Dropping 'run'
// freezes the count without reloading it.

module poll_divider
    import fpga_register_poller_pkg::*;
#(
    parameter int DIV = DEF_POLL_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int               CNT_W  = cnt_width(DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] ZERO   = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1'b1);

    logic [CNT_W-1:0] count_r;

    assign tick = run && (count_r == ZERO);

    // Down-count while running, reload at terminal count, hold when stopped.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= RELOAD;
        end else if (run) begin
            if (count_r == ZERO) begin
                count_r <= RELOAD;
            end else begin
                count_r <= count_r - ONE;
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/fpga_register_poller.sv
// fpga_register_poller
// Avalon-MM read master that periodically samples an 8-bit input-port
// slave (address 0, fixed read latency), keeps the latest byte and emits
// a one-cycle strobe with a per-bit change mask when the byte changes.
// Optional build macro FPGA_REGISTER_POLLER_TIMEOUT_EN adds a waitrequest
// watchdog that abandons a stalled read and raises a sticky timeout_err.

module fpga_register_poller
    import fpga_register_poller_pkg::*;
#(
    parameter int ADDR_W      = 2,
    parameter int DATA_W      = 32,
    parameter int VALUE_W     = 8,
    parameter int POLL_DIV    = DEF_POLL_DIV,
    parameter int READ_LAT    = DEF_READ_LAT,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               poll_now,
    output logic [ADDR_W-1:0]  avm_address,
    output logic               avm_read,
    input  logic               avm_waitrequest,
    input  logic [DATA_W-1:0]  avm_readdata,
    output logic [VALUE_W-1:0] value,
    output logic               value_valid,
    output logic [VALUE_W-1:0] change_mask,
    output logic               change_stb,
    output logic               busy,
    output logic               timeout_err
);

    localparam int               LAT_W    = cnt_width(READ_LAT);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LAT - 1);
    localparam logic [LAT_W-1:0] LAT_ZERO = LAT_W'(1'b0);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1'b1);
    localparam logic [VALUE_W-1:0] VAL_ZERO = VALUE_W'(1'b0);

    state_t             state_r;
    state_t             state_next_s;
    logic [LAT_W-1:0]   lat_cnt_r;
    logic               pending_r;

    logic               div_run_s;
    logic               div_tick_s;
    logic               poll_req_s;
    logic               accept_s;
    logic               capture_s;
    logic               timeout_hit_s;
    logic               avm_read_s;
    logic               busy_s;

    logic [VALUE_W-1:0] new_value_s;
    logic [VALUE_W-1:0] diff_s;

    logic [VALUE_W-1:0] value_r;
    logic               value_valid_r;
    logic [VALUE_W-1:0] change_mask_r;
    logic               change_stb_r;

    // ------------------------------------------------------------------
    // Poll request sources
    // ------------------------------------------------------------------
    // The divider only advances while idle and enabled, so a slow slave
    // stretches the poll period instead of queueing extra polls.
    assign div_run_s = enable && (state_r == IDLE);

    poll_divider #(
        .DIV (POLL_DIV)
    ) u_poll_divider (
        .clk   (clk),
        .reset (reset),
        .run   (div_run_s),
        .tick  (div_tick_s)
    );

    // A poll_now seen directly in IDLE starts the read without being latched.
    assign poll_req_s = pending_r || poll_now || div_tick_s;

    assign accept_s    = (state_r == REQ) && !avm_waitrequest;
    assign capture_s   = (state_r == WAIT) && (lat_cnt_r == LAT_ZERO);
    assign new_value_s = avm_readdata[VALUE_W-1:0];
    assign diff_s      = new_value_s ^ value_r;

    // Readdata bits above the value field carry nothing for this block.
    generate
        if (DATA_W > VALUE_W) begin : g_unused_hi
            logic unused_hi_s;
            assign unused_hi_s = ^avm_readdata[DATA_W-1:VALUE_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Optional waitrequest watchdog
    // ------------------------------------------------------------------
`ifdef FPGA_REGISTER_POLLER_TIMEOUT_EN
    localparam int              TO_W    = cnt_width(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_ZERO = TO_W'(1'b0);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1'b1);

    logic [TO_W-1:0] stall_cnt_r;
    logic            timeout_err_r;

    // The TIMEOUT_CYC-th consecutive stalled cycle abandons the read.
    assign timeout_hit_s = (state_r == REQ) && avm_waitrequest && (stall_cnt_r == TO_LAST);

    // Count consecutive stalled request cycles; latch a sticky error on expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r   <= TO_ZERO;
            timeout_err_r <= 1'b0;
        end else if (timeout_hit_s) begin
            stall_cnt_r   <= TO_ZERO;
            timeout_err_r <= 1'b1;
        end else if ((state_r == REQ) && avm_waitrequest) begin
            stall_cnt_r   <= stall_cnt_r + TO_ONE;
            timeout_err_r <= timeout_err_r;
        end else begin
            stall_cnt_r   <= TO_ZERO;
            timeout_err_r <= timeout_err_r;
        end
    end

    assign timeout_err = timeout_err_r;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign timeout_hit_s = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Poll FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (poll_req_s) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (accept_s) begin
                    state_next_s = WAIT;
                end else if (timeout_hit_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = REQ;
                end
            end
            WAIT: begin
                if (capture_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Bus and status outputs decoded from the current state.
    always_comb begin
        avm_read_s = 1'b0;
        busy_s     = 1'b0;
        case (state_r)
            IDLE: begin
                avm_read_s = 1'b0;
                busy_s     = 1'b0;
            end
            REQ: begin
                avm_read_s = 1'b1;
                busy_s     = 1'b1;
            end
            WAIT: begin
                avm_read_s = 1'b0;
                busy_s     = 1'b1;
            end
            default: begin
                avm_read_s = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
    end

    assign avm_read    = avm_read_s;
    assign busy        = busy_s;
    assign avm_address = ADDR_W'(VALUE_OFFSET);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Remember one poll_now that arrives while a read is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= 1'b0;
        end else if ((state_r == IDLE) && poll_req_s) begin
            pending_r <= 1'b0;
        end else if (poll_now) begin
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Read-latency counter: loaded on acceptance, counts down in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt_r <= LAT_ZERO;
        end else if (accept_s) begin
            lat_cnt_r <= LAT_LOAD;
        end else if ((state_r == WAIT) && (lat_cnt_r != LAT_ZERO)) begin
            lat_cnt_r <= lat_cnt_r - LAT_ONE;
        end else begin
            lat_cnt_r <= lat_cnt_r;
        end
    end

    // Sample capture, change mask and single-cycle change strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_r       <= VAL_ZERO;
            value_valid_r <= 1'b0;
            change_mask_r <= VAL_ZERO;
            change_stb_r  <= 1'b0;
        end else if (capture_s) begin
            value_r       <= new_value_s;
            value_valid_r <= 1'b1;
            change_mask_r <= diff_s;
            change_stb_r  <= value_valid_r && (diff_s != VAL_ZERO);
        end else begin
            value_r       <= value_r;
            value_valid_r <= value_valid_r;
            change_mask_r <= change_mask_r;
            change_stb_r  <= 1'b0;
        end
    end

    assign value       = value_r;
    assign value_valid = value_valid_r;
    assign change_mask = change_mask_r;
    assign change_stb  = change_stb_r;

endmodule

// File: tb/tb_fpga_register_poller.sv
// tb_fpga_register_poller
// Self-checking bench: a monitor predicts every capture from accepted
// reads (scoreboard queue) and checks value/mask/strobe on the cycle the
// capture becomes visible; a directed sequence covers reset, divider
// timing, waitrequest stalls, poll_now queueing, reset mid-read and the
// stall watchdog (FPGA_REGISTER_POLLER_TIMEOUT_EN selects its variant).

module tb_fpga_register_poller;

    localparam int POLL_DIV    = 8;
    localparam int READ_LAT    = 1;
    localparam int TIMEOUT_CYC = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        poll_now = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'h0000_005A;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic [7:0]  value;
    logic        value_valid;
    logic [7:0]  change_mask;
    logic        change_stb;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    fpga_register_poller #(
        .ADDR_W      (2),
        .DATA_W      (32),
        .VALUE_W     (8),
        .POLL_DIV    (POLL_DIV),
        .READ_LAT    (READ_LAT),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .poll_now        (poll_now),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .value           (value),
        .value_valid     (value_valid),
        .change_mask     (change_mask),
        .change_stb      (change_stb),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        int         due;
        logic [7:0] value;
        logic [7:0] mask;
        logic       stb;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_value = 8'h00;
    logic       model_valid = 1'b0;
    int         mcyc = 0;
    int         acc_cnt = 0;
    int         stb_seen = 0;

    // Monitor: mid-cycle sampling, scoreboard push on acceptance, pop on capture.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            mcyc++;
            if (change_stb === 1'b1) stb_seen++;
            if (reset) begin
                sb.delete();
                model_value = 8'h00;
                model_valid = 1'b0;
            end else begin
                if (sb.size() > 0 && sb[0].due == mcyc) begin
                    e = sb.pop_front();
                    check_val("sb_value", value, e.value);
                    check_val("sb_valid", value_valid, 1);
                    check_val("sb_mask", change_mask, e.mask);
                    check_val("sb_stb", change_stb, e.stb);
                end else begin
                    check_val("stb_quiet", change_stb, 0);
                end
                if (avm_read === 1'b1 && avm_waitrequest === 1'b0) begin
                    acc_cnt++;
                    e.due   = mcyc + READ_LAT + 1;
                    e.value = avm_readdata[7:0];
                    e.mask  = e.value ^ model_value;
                    e.stb   = model_valid && (e.mask != 8'h00);
                    model_value = e.value;
                    model_valid = 1'b1;
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic wait_read(input int max, output int n);
        n = 0;
        while (avm_read !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check_val("wait_read", avm_read, 1);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check_val("wait_idle", busy, 0);
    endtask

    task automatic wait_wait(input int max);
        int n = 0;
        while (!(busy === 1'b1 && avm_read === 1'b0) && n < max) begin
            @(negedge clk);
            n++;
        end
        check_val("wait_wait", {busy, avm_read}, 2'b10);
    endtask

    task automatic pulse_poll();
        poll_now = 1'b1;
        @(negedge clk);
        poll_now = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1);
    end

    initial begin : stim
        int n;
        int m;

        // Reset state.
        repeat (3) @(negedge clk);
        check_val("rst_read", avm_read, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_value", value, 0);
        check_val("rst_valid", value_valid, 0);
        check_val("rst_mask", change_mask, 0);
        check_val("rst_stb", change_stb, 0);
        check_val("rst_terr", timeout_err, 0);
        check_val("rst_addr", avm_address, 0);

        // First periodic poll: read appears POLL_DIV cycles after release.
        reset  = 1'b0;
        enable = 1'b1;
        wait_read(30, n);
        check_val("first_read_cyc", n, POLL_DIV);
        check_val("first_addr", avm_address, 0);
        n = 0;
        while (value_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("cap_lat", n, 2);
        check_val("value_5a", value, 8'h5A);
        check_val("busy_after", busy, 0);
        repeat (2) @(negedge clk);
        check_val("no_stb_first", stb_seen, 0);

        // Single-bit change on the next periodic poll.
        avm_readdata = 32'h0000_005B;
        wait_read(30, n);
        wait_idle(20);
        check_val("value_5b", value, 8'h5B);
        check_val("mask_01", change_mask, 8'h01);
        repeat (2) @(negedge clk);
        check_val("stb_once", stb_seen, 1);

        // Waitrequest stall of three cycles.
        avm_readdata    = 32'h0000_00C3;
        avm_waitrequest = 1'b1;
        wait_read(30, n);
        for (int i = 0; i < 3; i++) begin
            check_val("stall_read", avm_read, 1);
            check_val("stall_addr", avm_address, 0);
            @(negedge clk);
        end
        check_val("stall_read4", avm_read, 1);
        avm_waitrequest = 1'b0;
        @(negedge clk);
        check_val("wait_noread", avm_read, 0);
        check_val("wait_busy", busy, 1);
        @(negedge clk);
        check_val("stall_cap", value, 8'hC3);
        check_val("stall_idle", busy, 0);

        // Divider frozen; poll_now while idle and again during WAIT.
        enable       = 1'b0;
        avm_readdata = 32'h0000_003C;
        n = acc_cnt;
        repeat (30) @(negedge clk);
        check_val("frozen", acc_cnt - n, 0);
        pulse_poll();
        wait_wait(20);
        poll_now = 1'b1;
        @(negedge clk);
        poll_now = 1'b0;
        @(negedge clk);
        check_val("b2b_read", avm_read, 1);
        repeat (40) @(negedge clk);
        check_val("two_reads", acc_cnt - n, 2);
        check_val("value_3c", value, 8'h3C);

        // Reset during WAIT discards the in-flight read.
        avm_readdata = 32'h0000_00FF;
        pulse_poll();
        wait_wait(20);
        reset = 1'b1;
        @(negedge clk);
        check_val("rstw_read", avm_read, 0);
        check_val("rstw_busy", busy, 0);
        check_val("rstw_value", value, 0);
        check_val("rstw_valid", value_valid, 0);
        check_val("rstw_stb", change_stb, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_val("rstw_value2", value, 0);
        check_val("rstw_valid2", value_valid, 0);

        // Reset during a stalled REQ drops the read next cycle.
        avm_waitrequest = 1'b1;
        pulse_poll();
        wait_read(20, n);
        reset = 1'b1;
        @(negedge clk);
        check_val("rstq_drop", avm_read, 0);
        reset           = 1'b0;
        avm_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rstq_quiet", avm_read, 0);
        m = stb_seen;

        // Upper readdata bits ignored; first sample after reset never strobes.
        avm_readdata = 32'hABCD_EF81;
        pulse_poll();
        wait_read(20, n);
        wait_idle(20);
        check_val("value_81", value, 8'h81);
        check_val("valid_81", value_valid, 1);
        repeat (2) @(negedge clk);
        check_val("no_stb_after_rst", stb_seen - m, 0);
        avm_readdata = 32'h1234_567E;
        pulse_poll();
        wait_read(20, n);
        wait_idle(20);
        check_val("value_7e", value, 8'h7E);
        check_val("mask_ff", change_mask, 8'hFF);
        repeat (2) @(negedge clk);
        check_val("stb_ff", stb_seen - m, 1);

        // Waitrequest stuck high.
        avm_waitrequest = 1'b1;
        pulse_poll();
        wait_read(20, n);
`ifdef FPGA_REGISTER_POLLER_TIMEOUT_EN
        n = 0;
        while (avm_read === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("to_len", n, TIMEOUT_CYC);
        check_val("to_err", timeout_err, 1);
        check_val("to_busy", busy, 0);
        check_val("to_value", value, 8'h7E);
        avm_waitrequest = 1'b0;
        repeat (10) @(negedge clk);
        check_val("to_sticky", timeout_err, 1);
        check_val("to_value2", value, 8'h7E);
`else
        repeat (40) @(negedge clk);
        check_val("hang_read", avm_read, 1);
        check_val("hang_terr", timeout_err, 0);
        avm_waitrequest = 1'b0;
        wait_idle(20);
        check_val("hang_value", value, 8'h7E);
        check_val("hang_terr2", timeout_err, 0);
`endif

        repeat (3) @(negedge clk);
        check_val("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
